// File: rtl/elevator_call_scheduler.sv
// Collective-selective call scheduler for an NFLOOR elevator car: latches hall and
// car calls, picks the next motion step on each tick and runs the door dwell timer.
module elevator_call_scheduler #(
    parameter int NFLOOR = 8,
    parameter int DWELL  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NFLOOR:1]   hall_up,
    input  logic [NFLOOR:1]   hall_dn,
    input  logic [NFLOOR:1]   car_call,
    input  logic [NFLOOR:1]   cur_floor,
    input  logic              door_open_bt,
    input  logic              door_close_bt,
    output logic              move_up,
    output logic              move_dn,
    output logic              door_open,
    output logic [1:0]        state,
    output logic [4:0]        dwell_cnt,
    output logic [NFLOOR:1]   lamp_up,
    output logic [NFLOOR:1]   lamp_dn,
    output logic [NFLOOR:1]   lamp_car,
    output logic              pos_err
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_UP    = 2'b01;
    localparam logic [1:0] S_DN    = 2'b10;
    localparam logic [1:0] S_SERVE = 2'b11;

    localparam logic [4:0]        DWELL_LD = 5'(DWELL);
    localparam logic [NFLOOR:1]   UP_VALID = {1'b0, {(NFLOOR-1){1'b1}}};
    localparam logic [NFLOOR:1]   DN_VALID = {{(NFLOOR-1){1'b1}}, 1'b0};

    logic [NFLOOR:1] pend_up, pend_dn, pend_car, pend_all;
    logic [NFLOOR:1] above_mask, below_mask;
    logic [NFLOOR:1] clr_up, clr_dn, clr_car;
    logic            above, below, at_up, at_dn, at_car, at_any, here_up, here_dn;
    logic            onehot, step, serve_dir, serving;
    logic [1:0]      state_nxt;
    logic            dir_nxt, enter_serve, move_up_nxt, move_dn_nxt, door_nxt;
    logic [4:0]      dwell_nxt;

    assign lamp_up  = pend_up;
    assign lamp_dn  = pend_dn;
    assign lamp_car = pend_car;
    assign pend_all = pend_up | pend_dn | pend_car;

    assign onehot = (cur_floor != '0) && ((cur_floor & (cur_floor - 1'b1)) == '0);

    // Masks of the floors strictly above and strictly below the one-hot car position.
    always_comb begin
        logic seen_lo, seen_hi;
        seen_lo = 1'b0;
        seen_hi = 1'b0;
        above_mask = '0;
        below_mask = '0;
        for (int f = 1; f <= NFLOOR; f++) begin
            above_mask[f] = seen_lo;
            seen_lo = seen_lo | cur_floor[f];
        end
        for (int f = NFLOOR; f >= 1; f--) begin
            below_mask[f] = seen_hi;
            seen_hi = seen_hi | cur_floor[f];
        end
    end

    assign above   = |(pend_all & above_mask);
    assign below   = |(pend_all & below_mask);
    assign at_up   = |(pend_up & cur_floor);
    assign at_dn   = |(pend_dn & cur_floor);
    assign at_car  = |(pend_car & cur_floor);
    assign at_any  = at_up | at_dn | at_car;
    assign here_up = at_car | at_up;
    assign here_dn = at_car | at_dn;
    assign serving = (state == S_SERVE);

    // A bad position (registered or still present) freezes all stepping.
    assign step = tick & ~pos_err & onehot;

    always_comb begin
        state_nxt   = state;
        dir_nxt     = serve_dir;
        enter_serve = 1'b0;
        move_up_nxt = 1'b0;
        move_dn_nxt = 1'b0;
        door_nxt    = door_open;
        dwell_nxt   = dwell_cnt;
        if (step) begin
            case (state)
                S_IDLE: begin
                    if (at_any) begin
                        enter_serve = 1'b1;
                        dir_nxt     = at_up;
                    end else if (above) state_nxt = S_UP;
                    else if (below)     state_nxt = S_DN;
                end
                S_UP: begin
                    if (here_up) begin
                        enter_serve = 1'b1;
                        dir_nxt     = 1'b1;
                    end else if (!above && at_dn) begin
                        enter_serve = 1'b1;
                        dir_nxt     = 1'b0;
                    end else if (above) move_up_nxt = 1'b1;
                    else if (below)     state_nxt   = S_DN;
                    else                state_nxt   = S_IDLE;
                end
                S_DN: begin
                    if (here_dn) begin
                        enter_serve = 1'b1;
                        dir_nxt     = 1'b0;
                    end else if (!below && at_up) begin
                        enter_serve = 1'b1;
                        dir_nxt     = 1'b1;
                    end else if (below) move_dn_nxt = 1'b1;
                    else if (above)     state_nxt   = S_UP;
                    else                state_nxt   = S_IDLE;
                end
                default: begin
                    if (door_open_bt) begin
                        dwell_nxt = DWELL_LD;
                    end else if (dwell_cnt == 5'd0) begin
                        door_nxt = 1'b0;
                        if (serve_dir ? above : below) begin
                            state_nxt = serve_dir ? S_UP : S_DN;
                        end else if (serve_dir ? at_dn : at_up) begin
                            enter_serve = 1'b1;
                            dir_nxt     = ~serve_dir;
                        end else if (serve_dir ? below : above) begin
                            state_nxt = serve_dir ? S_DN : S_UP;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else if (door_close_bt) begin
                        dwell_nxt = 5'd0;
                    end else begin
                        dwell_nxt = dwell_cnt - 5'd1;
                    end
                end
            endcase
            if (enter_serve) begin
                state_nxt = S_SERVE;
                door_nxt  = 1'b1;
                dwell_nxt = DWELL_LD;
            end
        end
    end

    // Calls at the served floor are cleared on entry and absorbed for the whole stop.
    assign clr_car = (enter_serve | serving) ? cur_floor : '0;
    assign clr_up  = ((enter_serve & dir_nxt) | (serving & serve_dir)) ? cur_floor : '0;
    assign clr_dn  = ((enter_serve & ~dir_nxt) | (serving & ~serve_dir)) ? cur_floor : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_up   <= '0;
            pend_dn   <= '0;
            pend_car  <= '0;
            state     <= S_IDLE;
            serve_dir <= 1'b0;
            move_up   <= 1'b0;
            move_dn   <= 1'b0;
            door_open <= 1'b0;
            dwell_cnt <= 5'd0;
            pos_err   <= 1'b0;
        end else begin
            pend_up   <= (pend_up  | (hall_up & UP_VALID)) & ~clr_up;
            pend_dn   <= (pend_dn  | (hall_dn & DN_VALID)) & ~clr_dn;
            pend_car  <= (pend_car | car_call) & ~clr_car;
            state     <= state_nxt;
            serve_dir <= dir_nxt;
            move_up   <= move_up_nxt;
            move_dn   <= move_dn_nxt;
            door_open <= door_nxt;
            dwell_cnt <= dwell_nxt;
            pos_err   <= ~onehot;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed testbench for elevator_call_scheduler; the bench moves the car one floor
// per observed move pulse and checks against hand-computed expectations.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [8:1] hall_up, hall_dn, car_call, cur_floor;
    logic       door_open_bt, door_close_bt;
    logic       move_up, move_dn, door_open, pos_err;
    logic [1:0] state;
    logic [4:0] dwell_cnt;
    logic [8:1] lamp_up, lamp_dn, lamp_car;

    int n_checks = 0;
    int n_errors = 0;
    int up_pulses = 0;
    int dn_pulses = 0;

    elevator_call_scheduler #(.NFLOOR(8), .DWELL(5)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .hall_up(hall_up), .hall_dn(hall_dn), .car_call(car_call), .cur_floor(cur_floor),
        .door_open_bt(door_open_bt), .door_close_bt(door_close_bt),
        .move_up(move_up), .move_dn(move_dn), .door_open(door_open),
        .state(state), .dwell_cnt(dwell_cnt),
        .lamp_up(lamp_up), .lamp_dn(lamp_dn), .lamp_car(lamp_car), .pos_err(pos_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One tick with optional door buttons; the car model follows any move pulse.
    task automatic applyStimulus(input logic open_bt, input logic close_bt);
        @(negedge clk);
        tick = 1'b1;
        door_open_bt = open_bt;
        door_close_bt = close_bt;
        @(negedge clk);
        tick = 1'b0;
        door_open_bt = 1'b0;
        door_close_bt = 1'b0;
        if (move_up) begin
            up_pulses++;
            cur_floor = cur_floor << 1;
        end
        if (move_dn) begin
            dn_pulses++;
            cur_floor = cur_floor >> 1;
        end
    endtask

    task automatic press(input logic [8:1] up, input logic [8:1] dn, input logic [8:1] car);
        @(negedge clk);
        hall_up = up;
        hall_dn = dn;
        car_call = car;
        @(negedge clk);
        hall_up = '0;
        hall_dn = '0;
        car_call = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b0;
        hall_up = '0;
        hall_dn = '0;
        car_call = '0;
        door_open_bt = 1'b0;
        door_close_bt = 1'b0;
        cur_floor = 8'h01;
        @(negedge clk);
        rst = 1'b1;
        up_pulses = 0;
        dn_pulses = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        tick = 1'b0;
        hall_up = '0;
        hall_dn = '0;
        car_call = '0;
        door_open_bt = 1'b0;
        door_close_bt = 1'b0;
        cur_floor = 8'h01;
        repeat (3) @(negedge clk);
        checkOutput("rst_state", state, 2'b00);
        checkOutput("rst_door", door_open, 1'b0);
        checkOutput("rst_dwell", dwell_cnt, 5'd0);
        checkOutput("rst_poserr", pos_err, 1'b0);
        checkOutput("rst_lamps", {lamp_up, lamp_dn, lamp_car}, 24'h0);
        rst = 1'b1;

        // Idle car; top up-button and bottom down-button are not real calls.
        press(8'h80, 8'h01, 8'h00);
        checkOutput("ignored_hall_bits", {lamp_up, lamp_dn}, 16'h0);
        repeat (20) applyStimulus(1'b0, 1'b0);
        checkOutput("idle_pulses", up_pulses + dn_pulses, 0);
        checkOutput("idle_state", state, 2'b00);
        checkOutput("idle_door", door_open, 1'b0);

        // Single car call from floor 1 to floor 5.
        do_reset();
        press(8'h00, 8'h00, 8'h10);
        checkOutput("car5_lamp", lamp_car, 8'h10);
        applyStimulus(1'b0, 1'b0);
        checkOutput("car5_up_state", state, 2'b01);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("car5_pulses", up_pulses, 4);
        checkOutput("car5_floor", cur_floor, 8'h10);
        applyStimulus(1'b0, 1'b0);
        checkOutput("car5_serve", state, 2'b11);
        checkOutput("car5_door", door_open, 1'b1);
        checkOutput("car5_lamp_clr", lamp_car, 8'h00);
        checkOutput("car5_dwell_ld", dwell_cnt, 5'd5);
        for (int k = 4; k >= 0; k--) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("car5_dwell_dec", dwell_cnt, 5'(k));
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("car5_idle", state, 2'b00);
        checkOutput("car5_door_off", door_open, 1'b0);

        // Collective sweep: up 5, car 6, then reverse for down call at 4.
        do_reset();
        press(8'h10, 8'h08, 8'h20);
        checkOutput("sweep_lamps", {lamp_up, lamp_dn, lamp_car}, 24'h100820);
        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_at5", cur_floor, 8'h10);
        checkOutput("sweep_pulses", up_pulses, 4);
        checkOutput("sweep_dn4_held", lamp_dn, 8'h08);
        applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_serve5", state, 2'b11);
        checkOutput("sweep_lamps5", {lamp_up, lamp_dn, lamp_car}, 24'h000820);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_resume_up", state, 2'b01);
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_serve6", {state, cur_floor}, {2'b11, 8'h20});
        checkOutput("sweep_lamps6", {lamp_up, lamp_dn, lamp_car}, 24'h000800);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_reverse", state, 2'b10);
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_at4", cur_floor, 8'h08);
        checkOutput("sweep_dn_pulses", dn_pulses, 2);
        checkOutput("sweep_dn4_still", lamp_dn, 8'h08);
        applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_serve4", state, 2'b11);
        checkOutput("sweep_dn4_clr", lamp_dn, 8'h00);
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("sweep_idle", state, 2'b00);

        // Door buttons during a stop.
        do_reset();
        press(8'h00, 8'h00, 8'h01);
        applyStimulus(1'b0, 1'b0);
        checkOutput("door_serve", {state, dwell_cnt}, {2'b11, 5'd5});
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("door_dwell2", dwell_cnt, 5'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("door_open_reload", dwell_cnt, 5'd5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("door_close_zero", {door_open, dwell_cnt}, {1'b1, 5'd0});
        applyStimulus(1'b0, 1'b0);
        checkOutput("door_closed", {door_open, state}, {1'b0, 2'b00});

        // Position fault freezes motion, recovery resumes it.
        do_reset();
        press(8'h10, 8'h00, 8'h44);
        applyStimulus(1'b0, 1'b0);
        checkOutput("poserr_up", state, 2'b01);
        cur_floor = 8'h00;
        @(negedge clk);
        checkOutput("poserr_set", pos_err, 1'b1);
        up_pulses = 0;
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("poserr_no_pulse", up_pulses, 0);
        checkOutput("poserr_hold", state, 2'b01);
        cur_floor = 8'h01;
        @(negedge clk);
        checkOutput("poserr_clr", pos_err, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("poserr_resume", {up_pulses[7:0], cur_floor}, {8'd1, 8'h02});

        // Asynchronous reset in the middle of a move pulse.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checkOutput("areset_pulse", move_up, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("areset_move", {move_up, move_dn, door_open}, 3'b000);
        checkOutput("areset_state", state, 2'b00);
        checkOutput("areset_lamps", {lamp_up, lamp_dn, lamp_car}, 24'h0);
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
